frame_decoder: RTL and testbench

Receive-path byte-to-frame decoder: hunts for START_BYTE, removes escaping, strips START/STOP and emits payload as an AXI4-Stream frame with tlast on the final payload byte. It is the single-module inverse of the transmit chain (escape then frame) and sits between the UART/byte receiver and the frame consumer. Malformed frames (abort, overflow) are flagged on tuser rather than silently merged.

---
 rtl/framing_pkg.sv | 14 +
 rtl/frame_decoder.sv | 137 +++++++++++++
 tb/tb_frame_decoder.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/framing_pkg.sv
// rtl/framing_pkg.sv - shared framing byte codes and receive-state encoding
package framing_pkg;

    localparam logic [7:0] ESCAPE_BYTE = 8'h7F;
    localparam logic [7:0] START_BYTE  = 8'h7D;
    localparam logic [7:0] STOP_BYTE   = 8'h7E;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ESC  = 2'd2
    } frame_state_t;

endpackage

// File: rtl/frame_decoder.sv
// rtl/frame_decoder.sv - byte stream to AXI-Stream frame decoder (hunt, de-escape, strip START/STOP)
module frame_decoder
    import framing_pkg::*;
#(
    parameter int MAX_LEN = 256
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       target_tvalid,
    output logic       target_tready,
    input  logic [7:0] target_tdata,
    output logic       initiator_tvalid,
    input  logic       initiator_tready,
    output logic [7:0] initiator_tdata,
    output logic       initiator_tlast,
    output logic       initiator_tuser,
    output logic       stat_frame_ok,
    output logic       stat_frame_err
);

    localparam int CW = $clog2(MAX_LEN + 1);

    frame_state_t state_q, state_d;
    logic          hold_valid_q, hold_valid_d;
    logic [7:0]    hold_data_q, hold_data_d;
    logic [CW-1:0] count_q, count_d;

    logic accept;
    logic payload;
    logic emit, emit_last, emit_user;
    logic pulse_ok, pulse_err;

    assign target_tready = !areset && (!initiator_tvalid || initiator_tready);
    assign accept        = target_tvalid && target_tready;

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        count_d      = count_q;
        payload      = 1'b0;
        emit         = 1'b0;
        emit_last    = 1'b0;
        emit_user    = 1'b0;
        pulse_ok     = 1'b0;
        pulse_err    = 1'b0;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (target_tdata == START_BYTE) begin
                        state_d      = DATA;
                        hold_valid_d = 1'b0;
                        count_d      = '0;
                    end
                end
                DATA: begin
                    if (target_tdata == ESCAPE_BYTE) begin
                        state_d = ESC;
                    end else if (target_tdata == STOP_BYTE) begin
                        emit         = hold_valid_q;
                        emit_last    = 1'b1;
                        pulse_ok     = hold_valid_q;
                        hold_valid_d = 1'b0;
                        count_d      = '0;
                        state_d      = IDLE;
                    end else if (target_tdata == START_BYTE) begin
                        // Abort: close the open frame as errored and start the new one in place.
                        emit         = hold_valid_q;
                        emit_last    = 1'b1;
                        emit_user    = 1'b1;
                        pulse_err    = hold_valid_q;
                        hold_valid_d = 1'b0;
                        count_d      = '0;
                    end else begin
                        payload = 1'b1;
                    end
                end
                ESC: begin
                    payload = 1'b1;
                    state_d = DATA;
                end
                default: state_d = IDLE;
            endcase
        end

        if (payload) begin
            if (count_q == CW'(MAX_LEN)) begin
                // Overflow: hold is necessarily occupied since MAX_LEN >= 1.
                emit         = 1'b1;
                emit_last    = 1'b1;
                emit_user    = 1'b1;
                pulse_err    = 1'b1;
                hold_valid_d = 1'b0;
                count_d      = '0;
                state_d      = IDLE;
            end else begin
                emit         = hold_valid_q;
                hold_data_d  = target_tdata;
                hold_valid_d = 1'b1;
                count_d      = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q          <= IDLE;
            hold_valid_q     <= 1'b0;
            hold_data_q      <= 8'h00;
            count_q          <= '0;
            initiator_tvalid <= 1'b0;
            initiator_tdata  <= 8'h00;
            initiator_tlast  <= 1'b0;
            initiator_tuser  <= 1'b0;
            stat_frame_ok    <= 1'b0;
            stat_frame_err   <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_valid_q   <= hold_valid_d;
            hold_data_q    <= hold_data_d;
            count_q        <= count_d;
            stat_frame_ok  <= pulse_ok;
            stat_frame_err <= pulse_err;
            // emit only happens on accept, which already implies the output slot is free.
            if (emit) begin
                initiator_tvalid <= 1'b1;
                initiator_tdata  <= hold_data_q;
                initiator_tlast  <= emit_last;
                initiator_tuser  <= emit_user;
            end else if (initiator_tready) begin
                initiator_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_decoder.sv
// tb/tb_frame_decoder.sv - directed and randomised frame tests for frame_decoder
module tb_frame_decoder;

    localparam int MAX_LEN = 4;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic       target_tvalid = 1'b0;
    logic       target_tready;
    logic [7:0] target_tdata = 8'h00;
    logic       initiator_tvalid;
    logic       initiator_tready = 1'b1;
    logic [7:0] initiator_tdata;
    logic       initiator_tlast;
    logic       initiator_tuser;
    logic       stat_frame_ok;
    logic       stat_frame_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int ready_mode = 0;
    bit gaps = 0;
    logic [9:0] got[$];

    frame_decoder #(.MAX_LEN(MAX_LEN)) dut (
        .aclk(aclk),
        .areset(areset),
        .target_tvalid(target_tvalid),
        .target_tready(target_tready),
        .target_tdata(target_tdata),
        .initiator_tvalid(initiator_tvalid),
        .initiator_tready(initiator_tready),
        .initiator_tdata(initiator_tdata),
        .initiator_tlast(initiator_tlast),
        .initiator_tuser(initiator_tuser),
        .stat_frame_ok(stat_frame_ok),
        .stat_frame_err(stat_frame_err)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        cyc++;
        #1;
        case (ready_mode)
            0:       initiator_tready = 1'b1;
            1:       initiator_tready = 1'($urandom_range(0, 1));
            default: initiator_tready = 1'b0;
        endcase
    end

    // Output words are recorded as {tuser, tlast, tdata}.
    always @(negedge aclk) begin
        if (!areset) begin
            if (initiator_tvalid && initiator_tready)
                got.push_back({initiator_tuser, initiator_tlast, initiator_tdata});
            if (stat_frame_ok)  ok_cnt++;
            if (stat_frame_err) err_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        bit acc;
        if (gaps && $urandom_range(0, 2) == 0)
            repeat ($urandom_range(1, 2)) begin @(posedge aclk); #1; end
        target_tdata  = b;
        target_tvalid = 1'b1;
        n = 0;
        acc = 0;
        while (!acc && n < 100) begin
            @(negedge aclk);
            acc = target_tready;
            @(posedge aclk);
            #1;
            n++;
        end
        target_tvalid = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_byte_timeout byte=%02h not accepted within 100 cycles", b);
        end
    endtask

    task automatic send_bytes(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i]);
    endtask

    task automatic drain();
        ready_mode = 0;
        repeat (8) @(posedge aclk);
        #1;
    endtask

    task automatic clear_obs();
        got.delete();
        ok_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        tests++; if (target_tready !== 1'b0) begin fails++; $display("FAIL reset_target_tready got %b want 0", target_tready); end
        tests++; if (initiator_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %b want 0", initiator_tvalid); end
        tests++; if ({initiator_tuser, initiator_tlast, initiator_tdata} !== 10'h000) begin fails++; $display("FAIL reset_outputs got %03h want 000", {initiator_tuser, initiator_tlast, initiator_tdata}); end
        tests++; if ({stat_frame_ok, stat_frame_err} !== 2'b00) begin fails++; $display("FAIL reset_stats got %b want 00", {stat_frame_ok, stat_frame_err}); end
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        tests++; if (target_tready !== 1'b1) begin fails++; $display("FAIL post_reset_target_tready got %b want 1", target_tready); end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_basic();
        logic [9:0] exp[$] = '{10'h001, 10'h002, 10'h103};
        clear_obs();
        send_bytes('{8'h7D, 8'h01, 8'h02, 8'h03, 8'h7E});
        drain();
        tests++; if (got.size() !== exp.size()) begin fails++; $display("FAIL basic_len got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            logic [9:0] g = (i < got.size()) ? got[i] : 10'h3FF;
            tests++; if (g !== exp[i]) begin fails++; $display("FAIL basic_word[%0d] got %03h want %03h", i, g, exp[i]); end
        end
        tests++; if (ok_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL basic_stats got ok=%0d err=%0d want ok=1 err=0", ok_cnt, err_cnt); end
    endtask

    task automatic test_escape();
        logic [9:0] exp[$] = '{10'h07D, 10'h07E, 10'h17F};
        clear_obs();
        send_bytes('{8'h7D, 8'h7F, 8'h7D, 8'h7F, 8'h7E, 8'h7F, 8'h7F, 8'h7E});
        drain();
        tests++; if (got.size() !== exp.size()) begin fails++; $display("FAIL escape_len got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            logic [9:0] g = (i < got.size()) ? got[i] : 10'h3FF;
            tests++; if (g !== exp[i]) begin fails++; $display("FAIL escape_word[%0d] got %03h want %03h", i, g, exp[i]); end
        end
        tests++; if (ok_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL escape_stats got ok=%0d err=%0d want ok=1 err=0", ok_cnt, err_cnt); end
    endtask

    task automatic test_garbage_and_empty();
        logic [9:0] exp[$] = '{10'h155};
        clear_obs();
        send_bytes('{8'hAA, 8'h7E, 8'h7D, 8'h55, 8'h7E, 8'h7D, 8'h7E});
        drain();
        tests++; if (got.size() !== exp.size()) begin fails++; $display("FAIL garbage_len got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            logic [9:0] g = (i < got.size()) ? got[i] : 10'h3FF;
            tests++; if (g !== exp[i]) begin fails++; $display("FAIL garbage_word[%0d] got %03h want %03h", i, g, exp[i]); end
        end
        tests++; if (ok_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL garbage_stats got ok=%0d err=%0d want ok=1 err=0", ok_cnt, err_cnt); end
    endtask

    task automatic test_abort();
        logic [9:0] exp[$] = '{10'h011, 10'h322, 10'h133};
        clear_obs();
        send_bytes('{8'h7D, 8'h11, 8'h22, 8'h7D, 8'h33, 8'h7E});
        drain();
        tests++; if (got.size() !== exp.size()) begin fails++; $display("FAIL abort_len got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            logic [9:0] g = (i < got.size()) ? got[i] : 10'h3FF;
            tests++; if (g !== exp[i]) begin fails++; $display("FAIL abort_word[%0d] got %03h want %03h", i, g, exp[i]); end
        end
        tests++; if (ok_cnt !== 1 || err_cnt !== 1) begin fails++; $display("FAIL abort_stats got ok=%0d err=%0d want ok=1 err=1", ok_cnt, err_cnt); end
    endtask

    task automatic test_overflow();
        logic [9:0] exp[$] = '{10'h001, 10'h002, 10'h003, 10'h304, 10'h109};
        clear_obs();
        send_bytes('{8'h7D, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h7E, 8'h7D, 8'h09, 8'h7E});
        drain();
        tests++; if (got.size() !== exp.size()) begin fails++; $display("FAIL overflow_len got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            logic [9:0] g = (i < got.size()) ? got[i] : 10'h3FF;
            tests++; if (g !== exp[i]) begin fails++; $display("FAIL overflow_word[%0d] got %03h want %03h", i, g, exp[i]); end
        end
        tests++; if (ok_cnt !== 1 || err_cnt !== 1) begin fails++; $display("FAIL overflow_stats got ok=%0d err=%0d want ok=1 err=1", ok_cnt, err_cnt); end
    endtask

    task automatic test_latency();
        clear_obs();
        send_bytes('{8'h7D, 8'hA5});
        @(negedge aclk);
        tests++; if (initiator_tvalid !== 1'b0) begin fails++; $display("FAIL latency_held got tvalid=%b want 0", initiator_tvalid); end
        @(posedge aclk); #1;
        send_byte(8'h5A);
        @(negedge aclk);
        tests++; if ({initiator_tvalid, initiator_tuser, initiator_tlast, initiator_tdata} !== 11'h4A5) begin fails++; $display("FAIL latency_first got %03h want 4a5", {initiator_tvalid, initiator_tuser, initiator_tlast, initiator_tdata}); end
        @(posedge aclk); #1;
        send_byte(8'h7E);
        @(negedge aclk);
        tests++; if ({initiator_tvalid, initiator_tuser, initiator_tlast, initiator_tdata} !== 11'h55A) begin fails++; $display("FAIL latency_last got %03h want 55a", {initiator_tvalid, initiator_tuser, initiator_tlast, initiator_tdata}); end
        tests++; if ({stat_frame_ok, stat_frame_err} !== 2'b10) begin fails++; $display("FAIL latency_pulse got %b want 10", {stat_frame_ok, stat_frame_err}); end
        @(posedge aclk); #1;
        @(negedge aclk);
        tests++; if (stat_frame_ok !== 1'b0) begin fails++; $display("FAIL latency_pulse_width got %b want 0", stat_frame_ok); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp[$] = '{10'h001, 10'h002, 10'h003, 10'h104};
        int c0;
        clear_obs();
        c0 = cyc;
        send_bytes('{8'h7D, 8'h01, 8'h02, 8'h03, 8'h04, 8'h7E});
        tests++; if (cyc - c0 !== 6) begin fails++; $display("FAIL b2b_cycles got %0d want 6", cyc - c0); end
        drain();
        tests++; if (got.size() !== exp.size()) begin fails++; $display("FAIL b2b_len got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            logic [9:0] g = (i < got.size()) ? got[i] : 10'h3FF;
            tests++; if (g !== exp[i]) begin fails++; $display("FAIL b2b_word[%0d] got %03h want %03h", i, g, exp[i]); end
        end
        tests++; if (ok_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL b2b_stats got ok=%0d err=%0d want ok=1 err=0", ok_cnt, err_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] exp[$] = '{10'h005, 10'h106};
        clear_obs();
        ready_mode = 2;
        initiator_tready = 1'b0;
        send_bytes('{8'h7D, 8'h01, 8'h02});
        tests++; if (initiator_tvalid !== 1'b1) begin fails++; $display("FAIL midreset_pending got tvalid=%b want 1", initiator_tvalid); end
        areset = 1'b1;
        @(posedge aclk); #1;
        @(negedge aclk);
        tests++; if ({initiator_tvalid, target_tready} !== 2'b00) begin fails++; $display("FAIL midreset_outputs got %b want 00", {initiator_tvalid, target_tready}); end
        @(posedge aclk); #1;
        areset = 1'b0;
        ready_mode = 0;
        initiator_tready = 1'b1;
        send_bytes('{8'h03, 8'h7E, 8'h7D, 8'h05, 8'h06, 8'h7E});
        drain();
        tests++; if (got.size() !== exp.size()) begin fails++; $display("FAIL midreset_len got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            logic [9:0] g = (i < got.size()) ? got[i] : 10'h3FF;
            tests++; if (g !== exp[i]) begin fails++; $display("FAIL midreset_word[%0d] got %03h want %03h", i, g, exp[i]); end
        end
        tests++; if (ok_cnt !== 1 || err_cnt !== 0) begin fails++; $display("FAIL midreset_stats got ok=%0d err=%0d want ok=1 err=0", ok_cnt, err_cnt); end
    endtask

    task automatic test_random();
        logic [7:0] stream[$];
        logic [9:0] exp[$];
        logic [7:0] pl[$];
        logic [7:0] b;
        int exp_ok = 0;
        int exp_err = 0;
        int kind, len, shown;
        clear_obs();
        for (int f = 0; f <= 1000; f++) begin
            kind = (f == 1000) ? 9 : $urandom_range(0, 9);
            pl.delete();
            if (kind == 1) begin
                len = $urandom_range(MAX_LEN + 1, MAX_LEN + 2);
                for (int k = 0; k < len; k++) pl.push_back(8'($urandom_range(0, 8'h7C)));
            end else begin
                len = (kind == 2) ? 0 : $urandom_range(1, MAX_LEN);
                for (int k = 0; k < len; k++) begin
                    if ($urandom_range(0, 5) == 0) b = 8'($urandom_range(8'h7D, 8'h7F));
                    else b = 8'($urandom_range(0, 255));
                    pl.push_back(b);
                end
            end
            stream.push_back(8'h7D);
            foreach (pl[k]) begin
                if (pl[k] == 8'h7D || pl[k] == 8'h7E || pl[k] == 8'h7F) stream.push_back(8'h7F);
                stream.push_back(pl[k]);
            end
            if (kind != 0) stream.push_back(8'h7E);
            // kind 0 ends with no STOP, so the next frame's START aborts it
            if (kind == 1) begin
                for (int k = 0; k < MAX_LEN; k++)
                    exp.push_back({(k == MAX_LEN - 1), (k == MAX_LEN - 1), pl[k]});
                exp_err++;
            end else if (len > 0) begin
                for (int k = 0; k < len; k++)
                    exp.push_back({(kind == 0) && (k == len - 1), (k == len - 1), pl[k]});
                if (kind == 0) exp_err++;
                else exp_ok++;
            end
        end
        ready_mode = 1;
        gaps = 1;
        send_bytes(stream);
        gaps = 0;
        drain();
        tests++; if (got.size() !== exp.size()) begin fails++; $display("FAIL random_len got %0d want %0d", got.size(), exp.size()); end
        shown = 0;
        foreach (exp[i]) begin
            logic [9:0] g = (i < got.size()) ? got[i] : 10'h3FF;
            tests++;
            if (g !== exp[i]) begin
                fails++;
                if (shown < 10) $display("FAIL random_word[%0d] got %03h want %03h", i, g, exp[i]);
                shown++;
            end
        end
        tests++; if (ok_cnt !== exp_ok || err_cnt !== exp_err) begin fails++; $display("FAIL random_stats got ok=%0d err=%0d want ok=%0d err=%0d", ok_cnt, err_cnt, exp_ok, exp_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_escape();
        test_garbage_and_empty();
        test_abort();
        test_overflow();
        test_latency();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
